// File: rtl/filter_ds_axil_regs_pkg.sv
//------------------------------------------------------------------------------
// Module  : filter_ds_axil_pkg
// Purpose : Shared constants and FSM state types for the FILTER_DS_x8
//           AXI4-Lite configuration register bank.
// Ports   : none (package)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package filter_ds_axil_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Word index of each configuration register
  localparam int unsigned REG_CTRL  = 0;
  localparam int unsigned REG_COEF0 = 1;
  localparam int unsigned REG_COEF1 = 2;
  localparam int unsigned REG_COEF2 = 3;
  localparam int unsigned NUM_REGS  = 4;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_HAVE_AW = 2'd1,
    W_HAVE_W  = 2'd2,
    W_RESP    = 2'd3
  } w_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

endpackage

`default_nettype wire

// File: rtl/filter_ds_axil_regs_if.sv
//------------------------------------------------------------------------------
// Module  : filter_ds_axil_regs_if
// Purpose : AXI4-Lite bus bundle between the control-plane master and the
//           filter register bank.
// Ports   : AW/W/B/AR/R channel signals; modports master and slave.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface filter_ds_axil_regs_if #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

endinterface

`default_nettype wire

// File: rtl/filter_ds_axil_regs_strobe_merge.sv
//------------------------------------------------------------------------------
// Module  : axil_strobe_merge
// Purpose : Combinational byte-lane merge of AXI write data into an existing
//           register word, lane k taken from new data when strobe bit k is set.
// Ports   : i_old    - current register word
//           i_new    - incoming write data
//           i_strb   - byte strobes
//           o_merged - resulting word
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axil_strobe_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   i_old,
  input  logic [DATA_WIDTH-1:0]   i_new,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  output logic [DATA_WIDTH-1:0]   o_merged
);

  for (genvar k = 0; k < DATA_WIDTH/8; k++) begin : g_byte
    assign o_merged[8*k +: 8] = i_strb[k] ? i_new[8*k +: 8] : i_old[8*k +: 8];
  end

endmodule

`default_nettype wire

// File: rtl/filter_ds_axil_regs.sv
//------------------------------------------------------------------------------
// Module  : filter_ds_axil_regs
// Purpose : AXI4-Lite slave holding four 32-bit configuration registers for
//           the FILTER_DS_x8 downsampling filter. One write and one read may
//           be outstanding at a time, each handled by its own FSM.
// Ports   : ACLK, ARESETN - clock, asynchronous active-low reset
//           s_axi         - AXI4-Lite slave bus
//           cfg_reg       - registers 3..0 concatenated, reg0 in [31:0]
//           cfg_wr        - one-cycle pulse per register after each update
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module filter_ds_axil_regs
  import filter_ds_axil_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] RESET_VAL0         = 32'h0,
  parameter logic [31:0] RESET_VAL1         = 32'h0,
  parameter logic [31:0] RESET_VAL2         = 32'h0,
  parameter logic [31:0] RESET_VAL3         = 32'h0
) (
  input  logic                               ACLK,
  input  logic                               ARESETN,
  filter_ds_axil_regs_if.slave               s_axi,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_reg,
  output logic [NUM_REGS-1:0]                cfg_wr
);

  localparam int c_dw = C_S_AXI_DATA_WIDTH;
  localparam int c_sw = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [NUM_REGS*32-1:0] c_reset_vals =
    {RESET_VAL3, RESET_VAL2, RESET_VAL1, RESET_VAL0};

  w_state_t                      r_wstate;
  r_state_t                      r_rstate;
  logic                          r_awready, r_wready, r_bvalid;
  logic                          r_arready, r_rvalid;
  logic [1:0]                    r_bresp, r_rresp;
  logic [c_dw-1:0]               r_rdata;
  logic [C_S_AXI_ADDR_WIDTH-1:0] r_awaddr;
  logic [c_dw-1:0]               r_wdata;
  logic [c_sw-1:0]               r_wstrb;
  logic [c_dw-1:0]               r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]           r_cfg_wr;

  logic                          w_aw_hs, w_w_hs, w_ar_hs, w_wr_en;
  logic [C_S_AXI_ADDR_WIDTH-1:0] w_wr_addr;
  logic [1:0]                    w_wr_idx, w_rd_idx;
  logic [c_dw-1:0]               w_wr_data, w_merged;
  logic [c_sw-1:0]               w_wr_strb;
  logic                          w_unused_ok;

  assign w_aw_hs = s_axi.S_AXI_AWVALID && r_awready;
  assign w_w_hs  = s_axi.S_AXI_WVALID  && r_wready;
  assign w_ar_hs = s_axi.S_AXI_ARVALID && r_arready;

  // The register is written on the edge that completes the second of the
  // AW/W handshakes; whichever half arrived earlier comes from the latches.
  assign w_wr_en = ((r_wstate == W_IDLE)    && w_aw_hs && w_w_hs) ||
                   ((r_wstate == W_HAVE_AW) && w_w_hs) ||
                   ((r_wstate == W_HAVE_W)  && w_aw_hs);
  assign w_wr_addr = (r_wstate == W_HAVE_AW) ? r_awaddr : s_axi.S_AXI_AWADDR;
  assign w_wr_data = (r_wstate == W_HAVE_W)  ? r_wdata  : s_axi.S_AXI_WDATA;
  assign w_wr_strb = (r_wstate == W_HAVE_W)  ? r_wstrb  : s_axi.S_AXI_WSTRB;
  assign w_wr_idx  = w_wr_addr[3:2];
  assign w_rd_idx  = s_axi.S_AXI_ARADDR[3:2];

  // Byte offset and protection bits carry no meaning for this bank
  assign w_unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_ARADDR[1:0], w_wr_addr[1:0]};

  axil_strobe_merge #(.DATA_WIDTH(c_dw)) u_merge (
    .i_old    (r_regs[w_wr_idx]),
    .i_new    (w_wr_data),
    .i_strb   (w_wr_strb),
    .o_merged (w_merged)
  );

  // Write channel FSM. READY outputs are held low in reset and rise on the
  // first clock in W_IDLE.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_wstate  <= W_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= AXI_RESP_OKAY;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs && w_w_hs) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= AXI_RESP_OKAY;
          end else if (w_aw_hs) begin
            r_wstate  <= W_HAVE_AW;
            r_awaddr  <= s_axi.S_AXI_AWADDR;
            r_awready <= 1'b0;
          end else if (w_w_hs) begin
            r_wstate  <= W_HAVE_W;
            r_wdata   <= s_axi.S_AXI_WDATA;
            r_wstrb   <= s_axi.S_AXI_WSTRB;
            r_wready  <= 1'b0;
          end else begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        W_HAVE_AW: begin
          if (w_w_hs) begin
            r_wstate <= W_RESP;
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bresp  <= AXI_RESP_OKAY;
          end
        end
        W_HAVE_W: begin
          if (w_aw_hs) begin
            r_wstate  <= W_RESP;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= AXI_RESP_OKAY;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            r_wstate  <= W_IDLE;
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Register storage and the update pulse that follows each write
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= c_reset_vals[32*i +: 32];
      end
      r_cfg_wr <= '0;
    end else begin
      r_cfg_wr <= w_wr_en ? (NUM_REGS'(1) << w_wr_idx) : '0;
      if (w_wr_en) begin
        r_regs[w_wr_idx] <= w_merged;
      end
    end
  end

  // Read channel FSM. RDATA samples the register before any same-edge write
  // lands, so a colliding read returns the old value.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rresp   <= AXI_RESP_OKAY;
      r_rdata   <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rstate  <= R_DATA;
            r_rdata   <= r_regs[w_rd_idx];
            r_rresp   <= AXI_RESP_OKAY;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
          end else begin
            r_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = r_awready;
  assign s_axi.S_AXI_WREADY  = r_wready;
  assign s_axi.S_AXI_BVALID  = r_bvalid;
  assign s_axi.S_AXI_BRESP   = r_bresp;
  assign s_axi.S_AXI_ARREADY = r_arready;
  assign s_axi.S_AXI_RVALID  = r_rvalid;
  assign s_axi.S_AXI_RRESP   = r_rresp;
  assign s_axi.S_AXI_RDATA   = r_rdata;
  assign cfg_wr              = r_cfg_wr;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_cfg
    assign cfg_reg[c_dw*i +: c_dw] = r_regs[i];
  end

endmodule

`default_nettype wire

// File: tb/tb_filter_ds_axil_regs.sv
//------------------------------------------------------------------------------
// Module  : tb_filter_ds_axil_regs
// Purpose : Scoreboard bench for filter_ds_axil_regs. Stimulus tasks update a
//           behavioural register model and queue expected B/R responses and
//           cfg_wr pulses; an independent monitor pops and compares them.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_filter_ds_axil_regs;

  localparam logic [31:0] RV0 = 32'hA5A5_0000;
  localparam logic [31:0] RV1 = 32'h0000_1111;
  localparam logic [31:0] RV2 = 32'h2222_0000;
  localparam logic [31:0] RV3 = 32'h3333_3333;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [127:0] cfg_reg;
  logic [3:0]   cfg_wr;

  always #5 ACLK = ~ACLK;

  filter_ds_axil_regs_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) axi ();

  filter_ds_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4),
    .RESET_VAL0(RV0), .RESET_VAL1(RV1), .RESET_VAL2(RV2), .RESET_VAL3(RV3)
  ) dut (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .s_axi   (axi.slave),
    .cfg_reg (cfg_reg),
    .cfg_wr  (cfg_wr)
  );

  int          checks = 0;
  int          failures = 0;
  int          bp_mode = 0;   // 0 ready, 1 random, 2 BREADY low, 3 RREADY low
  logic [31:0] model [4];
  logic [1:0]  exp_b [$];
  logic [31:0] exp_r [$];
  int          exp_cfg_idx [$];
  logic [31:0] exp_cfg_val [$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got no handshake within bound, required one", name);
  endtask

  task automatic model_reset();
    model[0] = RV0; model[1] = RV1; model[2] = RV2; model[3] = RV3;
  endtask

  // Ready backpressure, driven away from the active edge
  initial begin
    axi.S_AXI_BREADY = 1'b1;
    axi.S_AXI_RREADY = 1'b1;
    forever begin
      @(posedge ACLK);
      #1;
      case (bp_mode)
        1:       begin axi.S_AXI_BREADY = 1'($urandom); axi.S_AXI_RREADY = 1'($urandom); end
        2:       begin axi.S_AXI_BREADY = 1'b0; axi.S_AXI_RREADY = 1'b1; end
        3:       begin axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b0; end
        default: begin axi.S_AXI_BREADY = 1'b1; axi.S_AXI_RREADY = 1'b1; end
      endcase
    end
  end

  // Monitor: a handshake seen at a falling edge completes on the next rise
  initial begin
    forever begin
      @(negedge ACLK);
      if (ARESETN) begin
        if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
          if (exp_b.size() == 0) chk("unexpected_b", 1'b1, 1'b0);
          else chk("bresp", axi.S_AXI_BRESP, exp_b.pop_front());
        end
        if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
          if (exp_r.size() == 0) chk("unexpected_r", 1'b1, 1'b0);
          else begin
            chk("rdata", axi.S_AXI_RDATA, exp_r.pop_front());
            chk("rresp", axi.S_AXI_RRESP, 2'b00);
          end
        end
        if (cfg_wr != 4'b0) begin
          if (exp_cfg_idx.size() == 0) chk("unexpected_cfg_wr", cfg_wr, 4'b0);
          else begin
            int          idx;
            logic [31:0] val;
            idx = exp_cfg_idx.pop_front();
            val = exp_cfg_val.pop_front();
            chk("cfg_wr", cfg_wr, 4'b0001 << idx);
            chk("cfg_reg_slice", cfg_reg[32*idx +: 32], val);
          end
        end
      end
    end
  end

  task automatic wait_b();
    int t = 0;
    while (!(axi.S_AXI_BVALID && axi.S_AXI_BREADY) && t < 200) begin
      @(negedge ACLK); t++;
    end
    if (t >= 200) tmo("b_handshake");
    else begin @(posedge ACLK); @(negedge ACLK); end
  endtask

  // Called on a falling edge; returns on a falling edge after the B handshake
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int awd, input int wd);
    int idx;
    idx = int'(addr[3:2]);
    for (int k = 0; k < 4; k++)
      if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
    exp_b.push_back(2'b00);
    exp_cfg_idx.push_back(idx);
    exp_cfg_val.push_back(model[idx]);
    fork
      begin
        int t = 0;
        repeat (awd) @(negedge ACLK);
        axi.S_AXI_AWADDR = addr; axi.S_AXI_AWVALID = 1'b1;
        while (!axi.S_AXI_AWREADY && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) tmo("aw_handshake");
        @(negedge ACLK);
        axi.S_AXI_AWVALID = 1'b0;
      end
      begin
        int t = 0;
        repeat (wd) @(negedge ACLK);
        axi.S_AXI_WDATA = data; axi.S_AXI_WSTRB = strb; axi.S_AXI_WVALID = 1'b1;
        while (!axi.S_AXI_WREADY && t < 50) begin @(negedge ACLK); t++; end
        if (t >= 50) tmo("w_handshake");
        @(negedge ACLK);
        axi.S_AXI_WVALID = 1'b0;
      end
    join
    chk("bvalid_latency", axi.S_AXI_BVALID, 1'b1);
    chk("ready_low_in_resp", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b00);
    wait_b();
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp, input int ard);
    int t = 0;
    exp_r.push_back(exp);
    repeat (ard) @(negedge ACLK);
    axi.S_AXI_ARADDR = addr; axi.S_AXI_ARVALID = 1'b1;
    while (!axi.S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) tmo("ar_handshake");
    @(negedge ACLK);
    axi.S_AXI_ARVALID = 1'b0;
    chk("rvalid_latency", axi.S_AXI_RVALID, 1'b1);
    t = 0;
    while (!(axi.S_AXI_RVALID && axi.S_AXI_RREADY) && t < 200) begin
      @(negedge ACLK); t++;
    end
    if (t >= 200) tmo("r_handshake");
    else begin @(posedge ACLK); @(negedge ACLK); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

  initial begin
    logic [3:0] a;
    int         t;
    axi.S_AXI_AWADDR = '0; axi.S_AXI_AWPROT = '0; axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WDATA = '0;  axi.S_AXI_WSTRB = '0;  axi.S_AXI_WVALID = 1'b0;
    axi.S_AXI_ARADDR = '0; axi.S_AXI_ARPROT = '0; axi.S_AXI_ARVALID = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("reset_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b000);
    chk("reset_valid", {axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 2'b00);
    chk("reset_resp_data", {axi.S_AXI_BRESP, axi.S_AXI_RRESP, axi.S_AXI_RDATA}, 36'h0);
    chk("reset_cfg_wr", cfg_wr, 4'b0);
    chk("reset_cfg_reg", cfg_reg, {RV3, RV2, RV1, RV0});
    @(negedge ACLK); ARESETN = 1'b1;
    @(negedge ACLK);
    chk("idle_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b111);

    // Sequential writes then reads
    for (int i = 0; i < 4; i++) axi_write(4'(4*i), 32'(i+1), 4'hF, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(4*i), 32'(i+1), 0);
    chk("cfg_reg_seq", cfg_reg, 128'h00000004_00000003_00000002_00000001);

    // Strobed write over reg1 (old value 2)
    axi_write(4'h4, 32'hAABB_CCDD, 4'b0101, 0, 0);
    axi_read(4'h4, 32'h00BB_00DD, 0);

    // AW leads W by 3 cycles, then W leads AW by 3 cycles
    axi_write(4'h0, 32'h1234_5678, 4'hF, 0, 3);
    axi_write(4'hC, 32'h9ABC_DEF0, 4'hF, 3, 0);
    axi_read(4'h0, 32'h1234_5678, 0);
    axi_read(4'hC, 32'h9ABC_DEF0, 0);

    // Read and write of reg2 handshaking on the same edge
    fork
      axi_write(4'h8, 32'h0000_0055, 4'hF, 0, 0);
      axi_read(4'h8, 32'h0000_0003, 0);
    join
    axi_read(4'h8, 32'h0000_0055, 0);

    // BREADY held low: response held, second AW refused (unaligned address)
    bp_mode = 2;
    fork
      axi_write(4'h9, 32'h0000_00C3, 4'hF, 0, 0);
    join_none
    repeat (2) @(negedge ACLK);
    for (int i = 0; i < 10; i++) begin
      axi.S_AXI_AWADDR = 4'h0; axi.S_AXI_AWVALID = 1'b1;
      chk("bvalid_held", axi.S_AXI_BVALID, 1'b1);
      chk("aw_w_blocked", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 2'b00);
      @(negedge ACLK);
    end
    axi.S_AXI_AWVALID = 1'b0;
    bp_mode = 0;
    wait fork;
    axi_read(4'hA, 32'h0000_00C3, 0);

    // Randomised traffic with random backpressure
    bp_mode = 1;
    for (int n = 0; n < 60; n++) begin
      a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)),
                  $urandom_range(0, 3), $urandom_range(0, 3));
      else
        axi_read(a, model[a[3:2]], $urandom_range(0, 2));
    end
    bp_mode = 0;
    repeat (2) @(negedge ACLK);

    // Reset mid-transaction: write parked in W_HAVE_AW, read data unacknowledged
    bp_mode = 3;
    repeat (2) @(negedge ACLK);
    axi.S_AXI_AWADDR = 4'h0; axi.S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!axi.S_AXI_AWREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) tmo("aw_pre_reset");
    @(negedge ACLK); axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_ARADDR = 4'h4; axi.S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!axi.S_AXI_ARREADY && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) tmo("ar_pre_reset");
    @(negedge ACLK); axi.S_AXI_ARVALID = 1'b0;
    chk("pre_reset_state", {axi.S_AXI_RVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 3'b101);
    #2 ARESETN = 1'b0;
    #1;
    chk("async_reset_valid", {axi.S_AXI_BVALID, axi.S_AXI_RVALID}, 2'b00);
    chk("async_reset_ready", {axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 3'b000);
    chk("async_reset_cfg_reg", cfg_reg, {RV3, RV2, RV1, RV0});
    model_reset();
    bp_mode = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    axi_write(4'h8, 32'hCAFE_F00D, 4'hF, 0, 1);
    axi_read(4'h8, 32'hCAFE_F00D, 0);
    axi_read(4'h4, RV1, 0);

    repeat (3) @(negedge ACLK);
    chk("scoreboard_drain", 32'(exp_b.size() + exp_r.size() + exp_cfg_idx.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/filter_ds_axil_regs.md
Name: filter_ds_axil_regs

Overview:
- AXI4-Lite slave register bank for the FILTER_DS_x8 downsampling filter.
- Answers the control-plane master, which is the PS or the AXI VIP master in simulation.
- Holds four 32-bit read/write configuration registers and drives them, with per-register write pulses, into the filter datapath.
- Single clock domain. One outstanding write and one outstanding read, handled independently.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; decodes 4 word registers.
- RESET_VAL0..RESET_VAL3, 32'h0, per-register reset values.

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1; S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32; S_AXI_WSTRB  in  4; S_AXI_WVALID  in  1; S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH; S_AXI_ARPROT  in  3  ignored; S_AXI_ARVALID  in  1; S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1.
- cfg_reg  out  128  registers 3..0 concatenated, reg0 in bits [31:0].
- cfg_wr  out  4  one-cycle pulse per register, asserted in the cycle after that register is updated.

Behaviour:
- Reset values: all READY, VALID, BRESP and RRESP outputs are 0. RDATA = 0. cfg_wr = 0. reg_n = RESET_VAL_n.
- Reset is asynchronous assert and synchronous deassert in use. Asserting reset mid-transaction aborts it with no response and no register change.
- Write FSM states:
  - W_IDLE: AWREADY = 1, WREADY = 1.
  - W_IDLE -> W_HAVE_AW when AW is accepted without W. Latch the address; AWREADY drops.
  - W_IDLE -> W_HAVE_W when W is accepted without AW. Latch data and strobe; WREADY drops.
  - W_IDLE -> W_RESP when AW and W are accepted in the same cycle.
  - W_HAVE_AW -> W_RESP on W handshake. W_HAVE_W -> W_RESP on AW handshake.
  - Entering W_RESP: write the register in that same clock edge and set BVALID = 1 with BRESP = OKAY.
  - W_RESP -> W_IDLE on BVALID && BREADY. AWREADY and WREADY stay 0 while in W_RESP.
  - Minimum write latency: BVALID is asserted 1 cycle after the AW/W handshake. A back-to-back write is accepted the cycle after the B handshake.
- Byte strobes: reg[8k+7:8k] updates only where WSTRB[k] = 1. WSTRB = 0 still produces an OKAY response, and cfg_wr still pulses.
- Address decode: index = addr[3:2]. addr[1:0] is ignored, so unaligned addresses map to the containing word. Every address in range, so BRESP and RRESP are always OKAY (2'b00).
- Read FSM states:
  - R_IDLE: ARREADY = 1.
  - R_IDLE -> R_DATA on AR handshake. RDATA is loaded with reg[index] at that edge; RVALID = 1, ARREADY = 0.
  - R_DATA -> R_IDLE on RVALID && RREADY.
  - RDATA and RVALID stay stable while RREADY is low.
  - Read latency: RVALID is asserted 1 cycle after the AR handshake.
- Simultaneous read and write to the same register in the same edge: the read returns the pre-write value. The write takes effect, and a later read returns the new value.
- cfg_wr[n] = 1 for exactly one cycle, the cycle following the update edge of reg n. cfg_reg reflects the new value in that same cycle.
- No combinational path from any input to any output. All outputs are registered.

Decomposition:
- Package filter_ds_axil_pkg holds:
  - AXI_RESP_OKAY = 2'b00.
  - Register index constants: REG_CTRL = 0, REG_COEF0 = 1, REG_COEF1 = 2, REG_COEF2 = 3.
  - Write state enum {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} and read state enum {R_IDLE, R_DATA}.
- Natural sub-module: axil_strobe_merge. It is combinational; given old word, new data and WSTRB it returns the merged word.

Test Plan:
- Sequential writes of 1, 2, 3, 4 to 0x0, 0x4, 0x8, 0xC, then reads of the same addresses -> every BRESP and RRESP is 0. Read data is 0x1, 0x2, 0x3, 0x4. cfg_reg = 128'h00000004_00000003_00000002_00000001.
- AW presented 3 cycles before W, then W presented 3 cycles before AW -> both land in W_RESP. BVALID is asserted 1 cycle after the second handshake. cfg_wr pulses once for each write.
- Write 0xAABBCCDD to 0x4 with WSTRB = 4'b0101 over an old value of 0x00000002 -> read returns 0x00BB00DD.
- BREADY held low for 10 cycles after a write -> BVALID stays 1, AWREADY and WREADY stay 0, and a second AW is not accepted until the B handshake.
- Read 0x8 and write 0x55 to 0x8 with handshakes in the same cycle -> RDATA = 0x3 (old value). A following read returns 0x55.
- ARESETN dropped while in W_HAVE_AW and during an unacknowledged R_DATA -> all VALIDs clear immediately and registers return to RESET_VAL. After release, a fresh write/read pair completes normally.
